// File: rtl/dm_byte_mem.sv
// M-stage data memory: byte-lane store merge and a combinational aligned-word read.
// Sub-word selection and load extension happen downstream.
module dm_byte_mem #(
  parameter int unsigned WORDS  = 1024,
  parameter bit          LOG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        MemWrite,
  input  logic [1:0]  StoreOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic [3:0]  BE
);

  localparam int unsigned AW = $clog2(WORDS);

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_RSV = 2'b11
  } store_op_t;

  logic [31:0]   mem [WORDS];
  logic [AW-1:0] index;
  store_op_t     op;
  logic [31:0]   lane_data;
  logic [31:0]   merged;

  assign index = Addr[AW+1:2];
  assign op    = store_op_t'(StoreOp);

  // Misaligned sw/sh are aligned down by ignoring the low address bits here.
  always_comb begin
    BE        = '0;
    lane_data = WD;
    if (MemWrite) begin
      unique case (op)
        OP_SW: begin
          BE        = 4'b1111;
          lane_data = WD;
        end
        OP_SH: begin
          BE        = Addr[1] ? 4'b1100 : 4'b0011;
          lane_data = {2{WD[15:0]}};
        end
        OP_SB: begin
          BE        = 4'b0001 << Addr[1:0];
          lane_data = {4{WD[7:0]}};
        end
        OP_RSV: begin
          BE        = '0;
          lane_data = WD;
        end
        default: begin
          BE        = '0;
          lane_data = WD;
        end
      endcase
    end
  end

  always_comb begin
    merged = mem[index];
    for (int unsigned b = 0; b < 4; b++) begin
      if (BE[b]) begin
        merged[b*8 +: 8] = lane_data[b*8 +: 8];
      end
    end
  end

  assign RD = mem[index];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (|BE) begin
      mem[index] <= merged;
    end
  end

`ifndef SYNTHESIS
  // Simulation only: known-zero contents before the first reset, and the store trace.
  initial begin
    for (int unsigned i = 0; i < WORDS; i++) begin
      mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (LOG_EN && !reset && (|BE)) begin
      $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

// File: tb/tb_dm_byte_mem.sv
// Checks dm_byte_mem against a byte-addressed reference memory, directed then random.
module tb_dm_byte_mem;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic        MemWrite;
  logic [1:0]  StoreOp;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [3:0]  BE;

  int unsigned nerr;
  int unsigned nchk;

  // Reference: 4 KiB of bytes, little-endian, address taken modulo the size.
  logic [7:0] rb [4096];

  dm_byte_mem #(.WORDS(1024), .LOG_EN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .PC       (PC),
    .MemWrite (MemWrite),
    .StoreOp  (StoreOp),
    .Addr     (Addr),
    .WD       (WD),
    .RD       (RD),
    .BE       (BE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int unsigned w;
    w = (a % 4096) & ~32'd3;
    return {rb[w+3], rb[w+2], rb[w+1], rb[w]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] wd);
    int unsigned sz;
    int unsigned base;
    logic [3:0]  ebe;
    @(negedge clk);
    reset = rst; MemWrite = we; StoreOp = op; Addr = a; WD = wd;
    PC = PC + 32'd4;
    #1;
    sz   = !we ? 0 : (op == 2'd0) ? 4 : (op == 2'd1) ? 2 : (op == 2'd2) ? 1 : 0;
    base = (sz == 0) ? a : (a & ~(sz - 1));
    ebe  = 4'(((1 << sz) - 1) << (base % 4));
    check("be", {28'd0, BE}, {28'd0, ebe});
    if (!rst) check("rd_before_store", RD, ref_word(a));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4096; i++) rb[i] = 8'h00;
    end else begin
      for (int k = 0; k < sz; k++) rb[(base + k) % 4096] = wd[8*k +: 8];
    end
    #1;
    check("rd_after_edge", RD, ref_word(a));
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] expv);
    @(negedge clk);
    reset = 1'b0; MemWrite = 1'b0; StoreOp = 2'b00; Addr = a; WD = 32'h0;
    #1;
    check("read_model", RD, ref_word(a));
    check("read_const", RD, expv);
  endtask

  initial begin
    nerr = 0; nchk = 0;
    for (int i = 0; i < 4096; i++) rb[i] = 8'h00;
    reset = 1'b1; MemWrite = 1'b0; StoreOp = 2'b00; Addr = '0; WD = '0; PC = 32'h0040_0000;

    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    read(32'h0,   32'h0);
    read(32'h4,   32'h0);
    read(32'hFFC, 32'h0);

    step(1'b0, 1'b1, 2'b00, 32'h10, 32'h1234_5678);
    read(32'h10, 32'h1234_5678);
    step(1'b0, 1'b1, 2'b10, 32'h11, 32'h0000_00AB);
    read(32'h10, 32'h1234_AB78);
    step(1'b0, 1'b1, 2'b01, 32'h12, 32'h0000_BEEF);
    read(32'h10, 32'hBEEF_AB78);

    step(1'b0, 1'b1, 2'b11, 32'h10, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 2'b00, 32'h10, 32'hDEAD_BEEF);
    read(32'h10, 32'hBEEF_AB78);

    // Misaligned sw/sh align down; back-to-back stores to one word compose.
    step(1'b0, 1'b1, 2'b00, 32'h33, 32'hA1B2_C3D4);
    step(1'b0, 1'b1, 2'b01, 32'h31, 32'h0000_5566);
    step(1'b0, 1'b1, 2'b10, 32'h33, 32'h0000_0077);
    read(32'h30, 32'h77B2_5566);

    step(1'b0, 1'b1, 2'b00, 32'h1010, 32'h0000_0001);
    read(32'h10, 32'h0000_0001);

    step(1'b1, 1'b1, 2'b00, 32'h20, 32'hFFFF_FFFF);
    read(32'h20, 32'h0);
    read(32'h10, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic        r;
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = a | ($urandom() & 32'hFFFF_F000);
      if ($urandom_range(0, 15) == 0) a = a | 32'hFC0;
      r = ($urandom_range(0, 99) == 0);
      step(r, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a, $urandom());
    end
    for (int w = 0; w < 16; w++) begin
      @(negedge clk);
      MemWrite = 1'b0; Addr = 32'(w * 4);
      #1;
      check("final_sweep", RD, ref_word(32'(w * 4)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
